// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - register file with hardwired zero, write bypass and busy scoreboard
module regfile_sb #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             ctrl_reset,
    input  logic             ctrl_writeEnable,
    input  logic [AW-1:0]    ctrl_writeReg,
    input  logic [WIDTH-1:0] data_writeReg,
    input  logic [AW-1:0]    ctrl_readRegA,
    input  logic [AW-1:0]    ctrl_readRegB,
    output logic [WIDTH-1:0] data_readRegA,
    output logic [WIDTH-1:0] data_readRegB,
    input  logic             ctrl_issueEnable,
    input  logic [AW-1:0]    ctrl_issueReg,
    output logic             busy_readRegA,
    output logic             busy_readRegB
);

    localparam bit ZERO_EN   = (ZERO_REG != 0);
    localparam bit BYPASS_EN = (BYPASS != 0);

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic             wr_ok;
    logic             iss_ok;

    assign wr_ok  = ctrl_writeEnable && !(ZERO_EN && (ctrl_writeReg == '0));
    assign iss_ok = ctrl_issueEnable && !(ZERO_EN && (ctrl_issueReg == '0));

    // Issue is applied after the write clear so a newer producer keeps the flag set.
    always_comb begin
        busy_d = busy_q;
        if (wr_ok) begin
            busy_d[ctrl_writeReg] = 1'b0;
        end
        if (iss_ok) begin
            busy_d[ctrl_issueReg] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i[AW-1:0]] <= '0;
            end
            busy_q <= '0;
        end else begin
            if (wr_ok) begin
                regs_q[ctrl_writeReg] <= data_writeReg;
            end
            busy_q <= busy_d;
        end
    end

    always_comb begin
        data_readRegA = regs_q[ctrl_readRegA];
        busy_readRegA = busy_q[ctrl_readRegA];
        if (ZERO_EN && (ctrl_readRegA == '0)) begin
            data_readRegA = '0;
            busy_readRegA = 1'b0;
        end else if (BYPASS_EN && ctrl_writeEnable && (ctrl_writeReg == ctrl_readRegA)) begin
            data_readRegA = data_writeReg;
            busy_readRegA = 1'b0;
        end
    end

    always_comb begin
        data_readRegB = regs_q[ctrl_readRegB];
        busy_readRegB = busy_q[ctrl_readRegB];
        if (ZERO_EN && (ctrl_readRegB == '0)) begin
            data_readRegB = '0;
            busy_readRegB = 1'b0;
        end else if (BYPASS_EN && ctrl_writeEnable && (ctrl_writeReg == ctrl_readRegB)) begin
            data_readRegB = data_writeReg;
            busy_readRegB = 1'b0;
        end
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised successor to the processor register file: a DEPTH x WIDTH register array with two combinational read ports and one clocked write port. Adds optional hardwired-zero register 0, optional write-to-read bypass, and a per-register busy scoreboard for in-flight writes. Sits in the decode stage of the pipelined core. Decode uses busy flags to stall; writeback drives the write port.

## Interface
Parameters:
- WIDTH, 32, data width in bits (>= 1).
- DEPTH, 32, number of registers (power of two, >= 2); AW = log2(DEPTH).
- ZERO_REG, 1, when 1 register 0 reads as 0, ignores writes and is never busy.
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- ctrl_reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- ctrl_writeEnable  in  1  commit data_writeReg to ctrl_writeReg at the next edge.
- ctrl_writeReg  in  AW  write address.
- data_writeReg  in  WIDTH  write data.
- ctrl_readRegA  in  AW  read address, port A.
- ctrl_readRegB  in  AW  read address, port B.
- data_readRegA  out  WIDTH  read data, port A (combinational).
- data_readRegB  out  WIDTH  read data, port B (combinational).
- ctrl_issueEnable  in  1  mark ctrl_issueReg busy at the next edge.
- ctrl_issueReg  in  AW  destination register of the issuing instruction.
- busy_readRegA  out  1  register at ctrl_readRegA has a pending write (combinational).
- busy_readRegB  out  1  register at ctrl_readRegB has a pending write (combinational).

## Operation
- State: array reg[0..DEPTH-1] of WIDTH bits; vector busy[0..DEPTH-1].
- Reset (ctrl_reset = 0, asynchronous): every reg = 0 and every busy = 0, immediately and while held. All read outputs therefore read 0 and all busy outputs read 0.
- Write: at the rising edge with ctrl_writeEnable = 1, reg[ctrl_writeReg] <= data_writeReg and busy[ctrl_writeReg] <= 0.
  - With ZERO_REG = 1, a write to address 0 is discarded.
- Issue: at the rising edge with ctrl_issueEnable = 1, busy[ctrl_issueReg] <= 1.
  - With ZERO_REG = 1, an issue to address 0 is discarded.
- Issue and write to the same register in the same cycle: busy ends at 1 (the newer producer wins). The write data is still stored.
- Issue and write to different registers in the same cycle: both updates happen.
- Read data, per port X in {A, B}:
  - ZERO_REG = 1 and address = 0: output 0.
  - Else, BYPASS = 1, ctrl_writeEnable = 1 and ctrl_writeReg = address: output data_writeReg.
  - Else: output reg[address].
- Busy output, per port X:
  - ZERO_REG = 1 and address = 0: output 0.
  - Else, BYPASS = 1 and a write hits the address this cycle: output 0.
  - Else: output busy[address].
  - A same-cycle issue does not affect busy outputs until after the edge.
- Both ports may read the same address; both return identical values.
- Addresses are always in range because DEPTH = 2^AW; there is no out-of-range behaviour.

## Timing
- Read and busy paths are purely combinational from addresses, the write port and state; 0-cycle latency.
- Write and issue take effect at the rising edge. With BYPASS = 0, written data is visible the cycle after the edge.
- Reset assertion is asynchronous. Deassertion must meet recovery/removal relative to clock; the first write is accepted at the first edge after deassertion.
- Reset asserted mid-operation discards a write or issue pending at that edge. State is all-zero after reset.
- No handshake: the write and issue ports are accepted unconditionally every cycle.

## Test plan
- Reset: load reg[5] = 0xDEADBEEF and busy[5] = 1, then pulse ctrl_reset = 0 mid-cycle -> data_readRegA(5) = 0 and busy_readRegA = 0 immediately, before the next edge.
- Write/read: write 0x12345678 to r7 at edge n -> data_readRegB(7) = 0x12345678 from cycle n+1. Write 0xFFFFFFFF to r0 -> reads 0 forever (ZERO_REG = 1).
- Bypass: in the same cycle, write 0xA5A5A5A5 to r3 and read r3 on A and B -> both outputs = 0xA5A5A5A5. Rebuild with BYPASS = 0 -> outputs show the old value until the next cycle.
- Scoreboard: issue r9 at edge n -> busy_readRegA(9) = 1 from n+1. Write r9 in cycle m -> busy = 0 combinationally in cycle m (BYPASS = 1), and the stored flag clears after edge m.
- Simultaneous issue and write to r9 in one cycle -> after the edge, busy[9] = 1 and reg[9] = the written data. Issue r0 -> busy_readRegA(0) stays 0.
- Parameter sweep: WIDTH = 8, DEPTH = 4; write 0x3C to r3, read on both ports -> 0x3C. Run random write/issue/read traffic against a reference model for 10k cycles with zero mismatches.
